// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C target receiver.
//
// Samples the externally driven SCL/SDA lines and detects START, repeated
// START and STOP. It matches a 7-bit address and shifts in write-data bytes
// MSB first. ACK/NACK is driven on SDA through an open-drain enable. Read
// requests and foreign addresses are ignored, so they are NACKed by the bus
// pull-up.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   scl_in     raw SCL pin level
//   sda_in     raw SDA pin level
//   sda_oe     1 = pull SDA low (ACK), 0 = release SDA
//   rx_data    last received data byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_ready   fabric can accept a byte; sampled when a byte completes
//   addressed  high from address ACK until STOP, repeated START or NACK
//   start_det  one-cycle pulse on START / repeated START
//   stop_det   one-cycle pulse on STOP
//   overrun    sticky; a byte was NACKed because rx_ready was low
//
// Build option:
//   I2C_GLITCH_FILTER_EN  when defined, each synchronized line only changes
//                         after FILTER_LEN consecutive identical samples.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    // Two-flop synchronizers, preset high so reset looks like an idle bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [3:0] scl_cnt;
    logic [3:0] sda_cnt;
    logic       scl_filt;
    logic       sda_filt;

    // Each counter tracks how many consecutive samples disagree with the
    // filtered level; the level flips on the FILTER_LEN-th disagreeing sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            if (scl_sync[1] == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == 4'(FILTER_LEN - 1)) begin
                scl_filt <= scl_sync[1];
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == 4'(FILTER_LEN - 1)) begin
                sda_filt <= sda_sync[1];
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    assign scl_f = scl_filt;
    assign sda_f = sda_filt;
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    // History flops: an edge is a difference between current and previous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic scl_stable_high;
    logic start_cond;
    logic stop_cond;

    assign scl_rise        = scl_f & ~scl_q;
    assign scl_fall        = ~scl_f & scl_q;
    // SCL high and not toggling: a simultaneous SCL/SDA edge is plain data.
    assign scl_stable_high = scl_f & scl_q;
    assign start_cond      = scl_stable_high & ~sda_f & sda_q;
    assign stop_cond       = scl_stable_high & sda_f & ~sda_q;

    state_t     state, state_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift, shift_next;
    logic [7:0] shift_in;
    logic [7:0] rx_data_next;
    logic       sda_oe_next;
    logic       rx_valid_next;
    logic       addressed_next;
    logic       start_det_next;
    logic       stop_det_next;
    logic       overrun_next;

    assign shift_in = {shift[6:0], sda_f};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            sda_oe    <= 1'b0;
            rx_valid  <= 1'b0;
            addressed <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            rx_data   <= rx_data_next;
            sda_oe    <= sda_oe_next;
            rx_valid  <= rx_valid_next;
            addressed <= addressed_next;
            start_det <= start_det_next;
            stop_det  <= stop_det_next;
            overrun   <= overrun_next;
        end
    end

    // In the ACK states the current sda_oe level tells which of the two
    // falling edges this is: the first grabs SDA, the second releases it.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        rx_data_next   = rx_data;
        sda_oe_next    = sda_oe;
        rx_valid_next  = 1'b0;
        addressed_next = addressed;
        start_det_next = 1'b0;
        stop_det_next  = 1'b0;
        overrun_next   = overrun;

        if (start_cond) begin
            start_det_next = 1'b1;
            state_next     = ADDR;
            bit_cnt_next   = '0;
            sda_oe_next    = 1'b0;
            addressed_next = 1'b0;
            overrun_next   = 1'b0;
        end else if (stop_cond) begin
            stop_det_next  = 1'b1;
            state_next     = IDLE;
            bit_cnt_next   = '0;
            sda_oe_next    = 1'b0;
            addressed_next = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = '0;
                            if (shift_in[7:1] == SLAVE_ADDR && !shift_in[0]) begin
                                state_next = ADDR_ACK;
                            end else begin
                                state_next = IGNORE;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_next    = 1'b1;
                            addressed_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = '0;
                            if (rx_ready) begin
                                rx_data_next  = shift_in;
                                rx_valid_next = 1'b1;
                                state_next    = DATA_ACK;
                            end else begin
                                overrun_next   = 1'b1;
                                addressed_next = 1'b0;
                                state_next     = IGNORE;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = DATA;
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_next = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
